// File: rtl/complete_arb_pkg.sv
// rtl/complete_arb_pkg.sv - shared completion types and lane count
package complete_arb_pkg;

  typedef logic       bool;
  typedef logic [5:0] phy_reg_t;
  typedef logic [4:0] rob_idx_t;

  typedef enum logic [3:0] {
    EXC_NONE            = 4'd0,
    EXC_INSN_MISALIGNED = 4'd1,
    EXC_ILLEGAL_INSN    = 4'd2,
    EXC_BREAKPOINT      = 4'd3,
    EXC_LOAD_FAULT      = 4'd5,
    EXC_STORE_FAULT     = 4'd7
  } exc_t;

  // Single source for the number of completion lanes.
  localparam int COMPLETE_WIDTH = 3;

endpackage

// File: rtl/complete_if.sv
// rtl/complete_if.sv - completion bus carrying WIDTH result lanes
interface complete
  import complete_arb_pkg::*;
#(
  parameter int WIDTH = COMPLETE_WIDTH
) ();

  logic [WIDTH-1:0] valid;
  phy_reg_t         dst       [WIDTH];
  rob_idx_t         rob_idx   [WIDTH];
  logic [WIDTH-1:0] exc_valid;
  exc_t             exc       [WIDTH];

  modport cq   (output valid, dst, rob_idx, exc_valid, exc);
  modport sink (input  valid, dst, rob_idx, exc_valid, exc);

endinterface

// File: rtl/rr_pick_n.sv
// rtl/rr_pick_n.sv - combinational round-robin pick of up to W of N requesters
module rr_pick_n #(
  parameter int N  = 5,
  parameter int W  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1,
  parameter int LW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_start,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_lane_idx [W],
  output logic [W-1:0]  o_lane_valid,
  output logic [PW-1:0] o_next_ptr
);

  localparam int CW = $clog2(W + 1);

  // Walk requesters from i_start with modulo-N wrap, filling lanes in scan order
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic [CW-1:0] cnt;
    sum          = '0;
    idx          = '0;
    cnt          = '0;
    o_grant      = '0;
    o_lane_valid = '0;
    o_next_ptr   = i_start;
    for (int k = 0; k < W; k++) begin
      o_lane_idx[k] = '0;
    end
    for (int j = 0; j < N; j++) begin
      sum = {1'b0, i_start} + (PW+1)'(j);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      idx = sum[PW-1:0];
      if (i_req[idx] && (cnt < CW'(W))) begin
        o_grant[idx]              = 1'b1;
        o_lane_idx[cnt[LW-1:0]]   = idx;
        o_lane_valid[cnt[LW-1:0]] = 1'b1;
        cnt                       = cnt + 1'b1;
        // The last grant in scan order decides where the next scan begins.
        o_next_ptr = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/complete_arb.sv
// rtl/complete_arb.sv - round-robin completion arbiter; COMPLETE_ARB_PERF_EN adds perf counters
module complete_arb
  import complete_arb_pkg::*;
#(
  parameter int NUM_REQ = 5,
  parameter int WIDTH   = COMPLETE_WIDTH
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic [NUM_REQ-1:0] req_valid,
  input  phy_reg_t           req_dst       [NUM_REQ],
  input  rob_idx_t           req_rob_idx   [NUM_REQ],
  input  logic [NUM_REQ-1:0] req_exc_valid,
  input  exc_t               req_exc       [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready,
`ifdef COMPLETE_ARB_PERF_EN
  output logic [31:0]        perf_grant_cnt,
  output logic [31:0]        perf_conflict_cnt,
`endif
  complete.cq                cdb
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      r_rr_ptr;
  logic [WIDTH-1:0]   r_valid;
  phy_reg_t           r_dst       [WIDTH];
  rob_idx_t           r_rob_idx   [WIDTH];
  logic [WIDTH-1:0]   r_exc_valid;
  exc_t               r_exc       [WIDTH];

  logic [NUM_REQ-1:0] w_valid_gated;
  logic [NUM_REQ-1:0] w_grant;
  logic [PW-1:0]      w_lane_idx  [WIDTH];
  logic [WIDTH-1:0]   w_lane_valid;
  logic [PW-1:0]      w_next_ptr;

  // A flushing cycle arbitrates nothing, so nothing is accepted from the units.
  assign w_valid_gated = flush ? '0 : req_valid;

  rr_pick_n #(
    .N (NUM_REQ),
    .W (WIDTH)
  ) u_pick (
    .i_req        (w_valid_gated),
    .i_start      (r_rr_ptr),
    .o_grant      (w_grant),
    .o_lane_idx   (w_lane_idx),
    .o_lane_valid (w_lane_valid),
    .o_next_ptr   (w_next_ptr)
  );

  // Grants are suppressed while reset is held so no result is lost to the clear.
  assign req_ready = reset_n ? w_grant : '0;

  // Pointer and output lanes: load granted payloads, zero unfilled lanes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr    <= '0;
      r_valid     <= '0;
      r_exc_valid <= '0;
      for (int k = 0; k < WIDTH; k++) begin
        r_dst[k]     <= '0;
        r_rob_idx[k] <= '0;
        r_exc[k]     <= EXC_NONE;
      end
    end else if (flush) begin
      r_rr_ptr    <= '0;
      r_valid     <= '0;
      r_exc_valid <= '0;
      for (int k = 0; k < WIDTH; k++) begin
        r_dst[k]     <= '0;
        r_rob_idx[k] <= '0;
        r_exc[k]     <= EXC_NONE;
      end
    end else begin
      r_rr_ptr <= w_next_ptr;
      for (int k = 0; k < WIDTH; k++) begin
        if (w_lane_valid[k]) begin
          r_valid[k]     <= 1'b1;
          r_dst[k]       <= req_dst[w_lane_idx[k]];
          r_rob_idx[k]   <= req_rob_idx[w_lane_idx[k]];
          r_exc_valid[k] <= req_exc_valid[w_lane_idx[k]];
          r_exc[k]       <= req_exc[w_lane_idx[k]];
        end else begin
          r_valid[k]     <= 1'b0;
          r_dst[k]       <= '0;
          r_rob_idx[k]   <= '0;
          r_exc_valid[k] <= 1'b0;
          r_exc[k]       <= EXC_NONE;
        end
      end
    end
  end

  assign cdb.valid     = r_valid;
  assign cdb.dst       = r_dst;
  assign cdb.rob_idx   = r_rob_idx;
  assign cdb.exc_valid = r_exc_valid;
  assign cdb.exc       = r_exc;

`ifdef COMPLETE_ARB_PERF_EN
  logic [31:0] r_perf_grant_cnt;
  logic [31:0] r_perf_conflict_cnt;

  // Free-running counters; only reset clears them, flush does not
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_grant_cnt    <= '0;
      r_perf_conflict_cnt <= '0;
    end else begin
      r_perf_grant_cnt <= r_perf_grant_cnt + 32'($countones(w_grant));
      if ($countones(w_valid_gated) > WIDTH) begin
        r_perf_conflict_cnt <= r_perf_conflict_cnt + 32'd1;
      end
    end
  end

  assign perf_grant_cnt    = r_perf_grant_cnt;
  assign perf_conflict_cnt = r_perf_conflict_cnt;
`endif

endmodule

// File: tb/tb_complete_arb.sv
// tb/tb_complete_arb.sv - directed self-checking bench for complete_arb
module tb_complete_arb;
  import complete_arb_pkg::*;

  localparam int NUM_REQ = 5;
  localparam int WIDTH   = COMPLETE_WIDTH;

  logic               clock;
  logic               reset_n;
  logic               flush;
  logic [NUM_REQ-1:0] req_valid;
  phy_reg_t           req_dst       [NUM_REQ];
  rob_idx_t           req_rob_idx   [NUM_REQ];
  logic [NUM_REQ-1:0] req_exc_valid;
  exc_t               req_exc       [NUM_REQ];
  logic [NUM_REQ-1:0] req_ready;
`ifdef COMPLETE_ARB_PERF_EN
  logic [31:0]        perf_grant_cnt;
  logic [31:0]        perf_conflict_cnt;
`endif

  int n_checks;
  int n_errors;

  complete #(.WIDTH(WIDTH)) cdb_if ();

  complete_arb #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .flush             (flush),
    .req_valid         (req_valid),
    .req_dst           (req_dst),
    .req_rob_idx       (req_rob_idx),
    .req_exc_valid     (req_exc_valid),
    .req_exc           (req_exc),
    .req_ready         (req_ready),
`ifdef COMPLETE_ARB_PERF_EN
    .perf_grant_cnt    (perf_grant_cnt),
    .perf_conflict_cnt (perf_conflict_cnt),
`endif
    .cdb               (cdb_if.cq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Default payload: requester i carries rob_idx 10+i and dst 20+i.
  task automatic load_payload();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_dst[i]       = 6'(20 + i);
      req_rob_idx[i]   = 5'(10 + i);
      req_exc_valid[i] = 1'b0;
      req_exc[i]       = EXC_NONE;
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    load_payload();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    flush     = 1'b0;
    req_valid = 5'b11111;
    load_payload();
    @(posedge clock);
    #1;
    n_checks++;
    if (req_ready !== 5'b00000) begin
      n_errors++;
      $display("FAIL reset_ready got %b want 00000", req_ready);
    end
    n_checks++;
    if (cdb_if.valid !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_cdb_valid got %b want 000", cdb_if.valid);
    end
    n_checks++;
    if (cdb_if.rob_idx[0] !== 5'd0 || cdb_if.dst[0] !== 6'd0) begin
      n_errors++;
      $display("FAIL reset_cdb_payload got rob %0d dst %0d want 0 0", cdb_if.rob_idx[0], cdb_if.dst[0]);
    end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 5'b00111) begin
      n_errors++;
      $display("FAIL reset_first_grant got %b want 00111", req_ready);
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (cdb_if.valid !== 3'b111 || cdb_if.rob_idx[0] !== 5'd10 ||
        cdb_if.rob_idx[1] !== 5'd11 || cdb_if.rob_idx[2] !== 5'd12) begin
      n_errors++;
      $display("FAIL reset_first_lanes got valid %b rob %0d %0d %0d want 111 10 11 12",
               cdb_if.valid, cdb_if.rob_idx[0], cdb_if.rob_idx[1], cdb_if.rob_idx[2]);
    end
  endtask

  task automatic test_oversub();
    logic [NUM_REQ-1:0] exp_ready [3];
    rob_idx_t           exp_rob   [3][3];
    exp_ready[0] = 5'b00111;
    exp_ready[1] = 5'b11001;
    exp_ready[2] = 5'b01110;
    exp_rob[0][0] = 5'd10; exp_rob[0][1] = 5'd11; exp_rob[0][2] = 5'd12;
    exp_rob[1][0] = 5'd13; exp_rob[1][1] = 5'd14; exp_rob[1][2] = 5'd10;
    exp_rob[2][0] = 5'd11; exp_rob[2][1] = 5'd12; exp_rob[2][2] = 5'd13;
    do_reset();
    req_valid = 5'b11111;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (req_ready !== exp_ready[c]) begin
        n_errors++;
        $display("FAIL oversub_ready cycle %0d got %b want %b", c, req_ready, exp_ready[c]);
      end
      @(posedge clock);
      #1;
      n_checks++;
      if (cdb_if.valid !== 3'b111) begin
        n_errors++;
        $display("FAIL oversub_valid cycle %0d got %b want 111", c, cdb_if.valid);
      end
      for (int k = 0; k < WIDTH; k++) begin
        n_checks++;
        if (cdb_if.rob_idx[k] !== exp_rob[c][k]) begin
          n_errors++;
          $display("FAIL oversub_rob cycle %0d lane %0d got %0d want %0d",
                   c, k, cdb_if.rob_idx[k], exp_rob[c][k]);
        end
      end
    end
`ifdef COMPLETE_ARB_PERF_EN
    n_checks++;
    if (perf_conflict_cnt !== 32'd3) begin
      n_errors++;
      $display("FAIL perf_conflict got %0d want 3", perf_conflict_cnt);
    end
    n_checks++;
    if (perf_grant_cnt !== 32'd9) begin
      n_errors++;
      $display("FAIL perf_grant got %0d want 9", perf_grant_cnt);
    end
`endif
  endtask

  // Single requester followed by a wrapped scan starting at requester 4.
  task automatic test_under_and_wrap();
    do_reset();
    req_rob_idx[3] = 5'd7;
    req_dst[3]     = 6'd12;
    req_valid      = 5'b01000;
    #1;
    n_checks++;
    if (req_ready !== 5'b01000) begin
      n_errors++;
      $display("FAIL under_ready got %b want 01000", req_ready);
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (cdb_if.valid !== 3'b001 || cdb_if.rob_idx[0] !== 5'd7 || cdb_if.dst[0] !== 6'd12) begin
      n_errors++;
      $display("FAIL under_lane0 got valid %b rob %0d dst %0d want 001 7 12",
               cdb_if.valid, cdb_if.rob_idx[0], cdb_if.dst[0]);
    end
    n_checks++;
    if (cdb_if.rob_idx[1] !== 5'd0 || cdb_if.dst[2] !== 6'd0) begin
      n_errors++;
      $display("FAIL under_empty_lanes got rob1 %0d dst2 %0d want 0 0", cdb_if.rob_idx[1], cdb_if.dst[2]);
    end
    req_valid = 5'b10011;
    #1;
    n_checks++;
    if (req_ready !== 5'b10011) begin
      n_errors++;
      $display("FAIL wrap_ready got %b want 10011", req_ready);
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (cdb_if.valid !== 3'b111 || cdb_if.rob_idx[0] !== 5'd14 ||
        cdb_if.rob_idx[1] !== 5'd10 || cdb_if.rob_idx[2] !== 5'd11) begin
      n_errors++;
      $display("FAIL wrap_lanes got valid %b rob %0d %0d %0d want 111 14 10 11",
               cdb_if.valid, cdb_if.rob_idx[0], cdb_if.rob_idx[1], cdb_if.rob_idx[2]);
    end
    req_valid = 5'b11111;
    #1;
    n_checks++;
    if (req_ready !== 5'b11100) begin
      n_errors++;
      $display("FAIL wrap_next_ptr got %b want 11100", req_ready);
    end
  endtask

  task automatic test_exception();
    do_reset();
    req_exc_valid[2] = 1'b1;
    req_exc[2]       = EXC_ILLEGAL_INSN;
    req_valid        = 5'b00101;
    #1;
    @(posedge clock);
    #1;
    n_checks++;
    if (cdb_if.valid !== 3'b011 || cdb_if.exc_valid !== 3'b010) begin
      n_errors++;
      $display("FAIL exc_flags got valid %b exc_valid %b want 011 010", cdb_if.valid, cdb_if.exc_valid);
    end
    n_checks++;
    if (cdb_if.exc[1] !== EXC_ILLEGAL_INSN || cdb_if.rob_idx[1] !== 5'd12) begin
      n_errors++;
      $display("FAIL exc_cause got exc %0d rob %0d want %0d 12", cdb_if.exc[1], cdb_if.rob_idx[1], EXC_ILLEGAL_INSN);
    end
  endtask

  task automatic test_flush();
    do_reset();
    req_valid = 5'b11111;
    @(posedge clock);
    #1;
    req_valid = 5'b00111;
    flush     = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 5'b00000) begin
      n_errors++;
      $display("FAIL flush_ready got %b want 00000", req_ready);
    end
    @(posedge clock);
    #1;
    flush = 1'b0;
    n_checks++;
    if (cdb_if.valid !== 3'b000) begin
      n_errors++;
      $display("FAIL flush_cdb_valid got %b want 000", cdb_if.valid);
    end
    req_valid = 5'b11111;
    #1;
    n_checks++;
    if (req_ready !== 5'b00111) begin
      n_errors++;
      $display("FAIL flush_restart got %b want 00111", req_ready);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_oversub();
    test_under_and_wrap();
    test_exception();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
